// File: rtl/wb_pkg.sv
// Shared types and sizing for the D-cache write-through buffer.
package wb_pkg;

    localparam int WB_DEPTH    = 4;
    localparam int WB_PTR_BITS = 2;
    localparam int WB_CNT_BITS = 3;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    function automatic logic [WB_PTR_BITS-1:0] ptr_inc(input logic [WB_PTR_BITS-1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side and memory-side signals of the write buffer.
interface write_buffer_if;
    logic        up_write_en;
    logic        up_read_en;
    logic [31:0] up_addr;
    logic [31:0] up_wdata;
    logic [31:0] up_rdata;
    logic        up_ready;
    logic        empty;
    logic [2:0]  count;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  up_write_en, up_read_en, up_addr, up_wdata, mem_rdata, mem_ready,
        output up_rdata, up_ready, empty, count, mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport master (
        output up_write_en, up_read_en, up_addr, up_wdata, mem_rdata, mem_ready,
        input  up_rdata, up_ready, empty, count, mem_read_en, mem_write_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wb_match.sv
// Youngest-match store-to-load forwarding search over the buffered entries.
module wb_match
    import wb_pkg::*;
(
    input  wb_entry_t                entries [WB_DEPTH],
    input  logic [WB_PTR_BITS-1:0]   head,
    input  logic [WB_CNT_BITS-1:0]   count,
    input  logic [29:0]              addr,
    output logic                     hit,
    output logic [31:0]              data
);

    logic [WB_PTR_BITS-1:0] idx_s;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        data  = 32'd0;
        idx_s = head;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx_s = head + WB_PTR_BITS'(i);
            if ((WB_CNT_BITS'(i) < count) && (entries[idx_s].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// 4-entry write-through store buffer with in-order drain and read forwarding.
module write_buffer
    import wb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    write_buffer_if.slave  bus
);

    wb_entry_t              entries_r [WB_DEPTH];
    logic [WB_PTR_BITS-1:0] head_r;
    logic [WB_PTR_BITS-1:0] tail_r;
    logic [WB_CNT_BITS-1:0] count_r;
    logic [WB_CNT_BITS-1:0] count_s;
    wb_state_e              state_r;
    wb_state_e              state_s;
    logic                   enq_s;
    logic                   wr_en_s;
    logic                   retire_s;
    logic                   hit_s;
    logic [31:0]            hit_data_s;

    assign enq_s    = bus.up_write_en && (count_r != 3'd4);
    // Reads own the memory port, so a read cycle never issues or retires a write.
    assign wr_en_s  = (state_r == ST_DRAIN) && (count_r != 3'd0) && !bus.up_read_en;
    assign retire_s = wr_en_s && bus.mem_ready;

    // Next occupancy from enqueue/retire; both together leave it unchanged.
    always_comb begin
        case ({enq_s, retire_s})
            2'b10:   count_s = count_r + 3'd1;
            2'b01:   count_s = count_r - 3'd1;
            default: count_s = count_r;
        endcase
    end

    // Drain FSM next state, tracking the post-edge occupancy.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_s != 3'd0) state_s = ST_DRAIN;
                else                 state_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (retire_s && (count_s == 3'd0)) state_s = ST_IDLE;
                else                               state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Pointer, occupancy and FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= 2'd0;
            tail_r  <= 2'd0;
            count_r <= 3'd0;
            state_r <= ST_IDLE;
        end else begin
            count_r <= count_s;
            state_r <= state_s;
            if (enq_s)    tail_r <= ptr_inc(tail_r);
            if (retire_s) head_r <= ptr_inc(head_r);
        end
    end

    // Entry payload storage; validity comes from head/count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_s) entries_r[tail_r] <= '{addr: bus.up_addr[31:2], data: bus.up_wdata};
    end

    wb_match u_match (
        .entries (entries_r),
        .head    (head_r),
        .count   (count_r),
        .addr    (bus.up_addr[31:2]),
        .hit     (hit_s),
        .data    (hit_data_s)
    );

    // Memory command and cache-facing outputs.
    always_comb begin
        bus.up_ready     = (count_r != 3'd4);
        bus.empty        = (count_r == 3'd0);
        bus.count        = count_r;
        bus.mem_read_en  = bus.up_read_en;
        bus.mem_write_en = wr_en_s;
        bus.up_rdata     = hit_s ? hit_data_s : bus.mem_rdata;
        if (bus.up_read_en) begin
            bus.mem_addr = bus.up_addr;
        end else if (wr_en_s) begin
            bus.mem_addr = {entries_r[head_r].addr, 2'b00};
        end else begin
            bus.mem_addr = 32'd0;
        end
        if (wr_en_s) bus.mem_wdata = entries_r[head_r].data;
        else         bus.mem_wdata = 32'd0;
    end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Clock and reset SHALL be one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 up_write_en  input  1  store from D-cache write-through path.
REQ-005 up_read_en  input  1  line-refill word read from D-cache.
REQ-006 up_addr  input  32  byte address; bits [1:0] ignored (word-aligned).
REQ-007 up_wdata  input  32  store data.
REQ-008 up_rdata  output  32  read data returned to the D-cache, combinational.
REQ-009 up_ready  output  1  1 = buffer not full; a store is accepted this cycle.
REQ-010 empty  output  1  1 = no buffered stores.
REQ-011 count  output  3  number of valid entries, 0..4.
REQ-012 mem_read_en, mem_write_en  output  1 each  backing-memory commands.
REQ-013 mem_addr, mem_wdata  output  32 each  backing-memory address and data.
REQ-014 mem_rdata  input  32  backing-memory read data, same cycle.
REQ-015 mem_ready  input  1  memory accepts the asserted write on this edge.

Function
REQ-016 The buffer SHALL be a 4-entry circular FIFO of {addr[31:2], data} with 2-bit head/tail pointers; pointers SHALL wrap 3->0.
REQ-017 A store with up_write_en=1 and up_ready=1 SHALL be enqueued at tail on that edge; with up_ready=0 it SHALL be dropped (the cache keeps the request held).
REQ-018 up_ready SHALL equal (count != 4) and SHALL be combinational from registered state only.
REQ-019 Reads SHALL pass through: when up_read_en=1, mem_read_en=1 and mem_addr=up_addr in the same cycle.
REQ-020 up_rdata SHALL equal the data of the youngest valid entry whose addr[31:2] matches up_addr[31:2]; if none matches, it SHALL equal mem_rdata.
REQ-021 A store enqueued in the same cycle as a read to the same word SHALL NOT be forwarded to that read.
REQ-022 The drain FSM SHALL have two states: IDLE and DRAIN.
REQ-023 IDLE->DRAIN SHALL occur when count != 0; DRAIN->IDLE SHALL occur when the head retires and count becomes 0.
REQ-024 In DRAIN with up_read_en=0, the block SHALL drive mem_write_en=1, mem_addr={head.addr,2'b00}, mem_wdata=head.data.
REQ-025 The head SHALL retire (head+1, count-1) on an edge where mem_write_en=1 and mem_ready=1.
REQ-026 A read SHALL preempt the drain: when up_read_en=1, mem_write_en=0, the head SHALL not retire, and draining SHALL resume the next non-read cycle.
REQ-027 Simultaneous enqueue and retire SHALL leave count unchanged; enqueue at count=4 concurrent with a retire SHALL still be rejected (up_ready is computed from registered count).
REQ-028 Stores SHALL be written to memory in strict program order, with no coalescing.
REQ-029 When neither port is active, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-030 While reset=0, head, tail and count SHALL be 0, the FSM SHALL be in IDLE, all entries SHALL be invalid, and empty SHALL be 1.
REQ-031 Reset SHALL discard pending stores, including an entry mid-drain; no write SHALL be issued after the reset edge.
REQ-032 The entry data storage need not be reset.

Structure
REQ-033 A shared package wb_pkg SHALL hold WB_DEPTH=4, WB_PTR_BITS=2, the entry struct {addr[29:0], data[31:0]}, and the FSM state enum.
REQ-034 A combinational sub-module wb_match SHALL implement the youngest-match forwarding search over the 4 entries, given head, count and the lookup address.

Verification
REQ-035 Store 0x100<-0xAAAA0001, mem_ready=1 always -> mem_write_en asserted the next cycle with addr 0x100; empty=1 two cycles after the store.
REQ-036 mem_ready=0; 5 stores to 0x0,0x4,0x8,0xC,0x10 -> up_ready=0 after the 4th; the 5th is dropped; count=4.
REQ-037 Buffer holds 0x40<-1 then 0x40<-2, mem_rdata=0xDEAD; read 0x40 -> up_rdata=2; read 0x44 -> 0xDEAD.
REQ-038 Draining head with mem_ready=1 while up_read_en=1 for 3 cycles -> mem_write_en=0 for those cycles, count unchanged; the head is written on the 4th cycle.
REQ-039 count=4, mem_ready=1, and a store is offered in the same cycle -> the store is rejected and count=3 after the edge; the retry next cycle is accepted and count stays 3.
REQ-040 Assert reset mid-drain with count=3 -> outputs go 0 and empty=1 immediately; no mem_write_en is issued after reset is released with no new stores.
